// File: rtl/capture_game_pkg.sv
// capture_game_pkg: shared types and constants for the capture game sequencer.
//   state_t    - FSM state encoding, also driven out on o_state
//   SLOT_CNT   - number of slot flags in the capture-tracking memory
//   WIN_MASK   - slots that must all be captured to win (slot 0 is reserved)
//   LFSR_TAPS  - feedback taps of the 8-bit encounter LFSR (x^8+x^6+x^5+x^4+1)
package capture_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_SPAWN   = 3'd2,
    ST_AIM     = 3'd3,
    ST_RESOLVE = 3'd4,
    ST_CHECK   = 3'd5,
    ST_OVER    = 3'd6
  } state_t;

  localparam int unsigned            SLOT_CNT  = 7;
  localparam logic [SLOT_CNT-1:0]    WIN_MASK  = 7'b1111110;
  // Polynomial taps 8,6,5,4 map to register bits 7,5,4,3.
  localparam logic [7:0]             LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: 8-bit Fibonacci LFSR that picks the next encounter index.
//   clk_i   - clock
//   rst_ni  - asynchronous reset, active low (reloads P_SEED)
//   en_i    - advance one step this cycle
//   idx_o   - current state folded into 0..5
module game_lfsr
  import capture_game_pkg::*;
#(
  parameter logic [7:0] P_SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [2:0] idx_o
);

  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   lfsr_q <= P_SEED;
    else if (en_i) lfsr_q <= lfsr_d;
  end

  // Fold 6 and 7 back onto 0 and 1 so the memory never sees slot 7 or 8.
  assign idx_o = (lfsr_q[2:0] > 3'd5) ? (lfsr_q[2:0] - 3'd6) : lfsr_q[2:0];

endmodule

// File: rtl/capture_game_ctrl.sv
// capture_game_ctrl: round sequencer for the capture-tracking memory.
//   i_clk/i_rst_n      - clock, asynchronous active-low reset
//   i_start, i_throw   - single-cycle button pulses
//   i_capture_vec      - slot flags read back from the memory
//   o_restart/o_refresh/o_random/o_capture - memory control strobes and data
//   o_pos, o_balls     - aim-marker position, balls remaining
//   o_state, o_over, o_win - FSM state and game result
module capture_game_ctrl
  import capture_game_pkg::*;
#(
  parameter int unsigned P_BALLS    = 10,
  parameter int unsigned P_SWEEP    = 16,
  parameter int unsigned P_HIT_WIN  = 4,
  parameter int unsigned P_STEP_CYC = 2,
  parameter int unsigned P_AIM_CYC  = 64,
  parameter logic [7:0]  P_SEED     = 8'hA5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_throw,
  input  logic [SLOT_CNT-1:0] i_capture_vec,
  output logic                o_restart,
  output logic                o_refresh,
  output logic [2:0]          o_random,
  output logic                o_capture,
  output logic [3:0]          o_pos,
  output logic [3:0]          o_balls,
  output logic [2:0]          o_state,
  output logic                o_over,
  output logic                o_win
);

  localparam int unsigned STEP_W    = (P_STEP_CYC > 1) ? $clog2(P_STEP_CYC) : 1;
  localparam int unsigned TMO_W     = $clog2(P_AIM_CYC);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(P_STEP_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(P_AIM_CYC - 1);
  localparam logic [3:0]        POS_LAST  = 4'(P_SWEEP - 1);
  localparam logic [4:0]        HIT_LIM   = 5'(P_HIT_WIN);
  localparam logic [3:0]        BALLS_INI = 4'(P_BALLS);

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [3:0]        pos_q, balls_q;
  logic [2:0]        random_q;
  logic              restart_q, refresh_q, capture_q, over_q, win_q;
  logic [2:0]        lfsr_idx;

  game_lfsr #(.P_SEED(P_SEED)) u_lfsr (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (state_q != ST_IDLE),
    .idx_o  (lfsr_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      tmo_q     <= '0;
      pos_q     <= '0;
      balls_q   <= BALLS_INI;
      random_q  <= '0;
      restart_q <= 1'b0;
      refresh_q <= 1'b0;
      capture_q <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      // Strobes (and the capture bit riding on refresh) are one-cycle pulses.
      restart_q <= 1'b0;
      refresh_q <= 1'b0;
      capture_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            state_q   <= ST_RESTART;
            restart_q <= 1'b1;
            balls_q   <= BALLS_INI;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
          end
        end
        ST_RESTART: begin
          // First encounter is loaded with no capture attached.
          state_q   <= ST_SPAWN;
          refresh_q <= 1'b1;
          random_q  <= lfsr_idx;
          pos_q     <= '0;
          step_q    <= '0;
          tmo_q     <= '0;
        end
        ST_SPAWN: state_q <= ST_AIM;
        ST_AIM: begin
          if (i_throw) begin
            // Throw takes priority over a coinciding timeout.
            state_q   <= ST_RESOLVE;
            refresh_q <= 1'b1;
            capture_q <= ({1'b0, pos_q} < HIT_LIM);
            random_q  <= lfsr_idx;
            balls_q   <= balls_q - 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            // Encounter flees: recorded as a miss, ball kept.
            state_q   <= ST_RESOLVE;
            refresh_q <= 1'b1;
            random_q  <= lfsr_idx;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (step_q == STEP_LAST) begin
              step_q <= '0;
              pos_q  <= (pos_q == POS_LAST) ? 4'd0 : pos_q + 1'b1;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        ST_RESOLVE: state_q <= ST_CHECK;
        ST_CHECK: begin
          // The memory has absorbed the RESOLVE strobe by this cycle.
          if ((i_capture_vec & WIN_MASK) == WIN_MASK) begin
            state_q <= ST_OVER;
            over_q  <= 1'b1;
            win_q   <= 1'b1;
          end else if (balls_q == 4'd0) begin
            state_q <= ST_OVER;
            over_q  <= 1'b1;
          end else begin
            state_q <= ST_AIM;
            pos_q   <= '0;
            step_q  <= '0;
            tmo_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_restart = restart_q;
  assign o_refresh = refresh_q;
  assign o_random  = random_q;
  assign o_capture = capture_q;
  assign o_pos     = pos_q;
  assign o_balls   = balls_q;
  assign o_state   = state_q;
  assign o_over    = over_q;
  assign o_win     = win_q;

endmodule

// File: tb/tb_capture_game_ctrl.sv
// tb_capture_game_ctrl: randomized bench for capture_game_ctrl with an attached
// capture-memory model and a round-level reference model of the game rules.
module tb_capture_game_ctrl;

  localparam logic [7:0] SEED = 8'hA5;

  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_throw = 1'b0;
  logic [6:0] i_capture_vec;
  logic       o_restart, o_refresh, o_capture, o_over, o_win;
  logic [2:0] o_random, o_state;
  logic [3:0] o_pos, o_balls;

  capture_game_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_throw(i_throw),
    .i_capture_vec(i_capture_vec),
    .o_restart(o_restart), .o_refresh(o_refresh), .o_random(o_random),
    .o_capture(o_capture), .o_pos(o_pos), .o_balls(o_balls),
    .o_state(o_state), .o_over(o_over), .o_win(o_win)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Encounter index rules: next LFSR value and the fold of its low 3 bits into 0..5.
  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  function automatic int map6(input logic [7:0] v);
    return (int'(v) % 8) % 6;
  endfunction

  // LFSR runs from the first start onward. m_prev is the value the DUT used at the
  // most recent clock edge.
  logic       m_run = 1'b0;
  logic [7:0] m_lfsr = SEED, m_prev = SEED;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_run <= 1'b0; m_lfsr <= SEED; m_prev <= SEED;
    end else begin
      if (m_run) begin m_prev <= m_lfsr; m_lfsr <= lfsr_nx(m_lfsr); end
      if (i_start) m_run <= 1'b1;
    end
  end

  // Capture-tracking memory: refresh records the current encounter, loads the next.
  logic [6:0] mem_q = '0;
  logic [2:0] mem_cur = '0;
  bit         force_win = 1'b0;
  int         mk;
  assign i_capture_vec = force_win ? 7'b1111110 : mem_q;
  always @(posedge i_clk) begin
    if (o_restart) mem_q <= '0;
    else if (o_refresh) begin
      mk = int'(mem_cur) + 1;
      if (o_capture && mk < 7) mem_q[mk] <= 1'b1;
      mem_cur <= o_random;
    end
  end

  // Game-level reference state.
  int         exp_balls, exp_idx, n_refresh = 0;
  logic [6:0] exp_slots;
  bit         ov;

  task automatic chk_refresh(input string tag, input int cap);
    chk({tag, "_refresh"}, o_refresh, 1);
    chk({tag, "_capture"}, o_capture, cap);
    chk({tag, "_random"}, o_random, map6(m_prev));
    chk({tag, "_range"}, (o_random < 3'd6), 1);
    n_refresh++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_strobes"}, {o_restart, o_refresh, o_capture}, 0);
    chk({tag, "_random"}, o_random, 0);
    chk({tag, "_pos"}, o_pos, 0);
    chk({tag, "_balls"}, o_balls, 10);
    chk({tag, "_overwin"}, {o_over, o_win}, 0);
  endtask

  // Called at a negedge while the DUT sits in IDLE or OVER; returns in AIM cycle 0.
  task automatic start_game();
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("restart_state", o_state, 1);
    chk("restart_strobe", o_restart, 1);
    chk("restart_overwin", {o_over, o_win}, 0);
    tick();
    chk("spawn_state", o_state, 2);
    chk("spawn_restart", o_restart, 0);
    chk_refresh("spawn", 0);
    exp_idx = map6(m_prev); exp_balls = 10; exp_slots = '0;
    tick();
    chk("aim_state", o_state, 3);
    chk("aim_balls", o_balls, exp_balls);
  endtask

  // thr: AIM cycle of the throw (-1 = let it time out). spur: fire ignored pulses.
  task automatic play_round(input int thr, input bit spur, input bit fw, output bit over);
    bit hit, win;
    hit = 1'b0;
    for (int c = 0; c < 64; c++) begin
      chk("aim_pos", o_pos, (c / 2) % 16);
      chk("aim_hold", o_state, 3);
      if (c == thr) begin
        i_throw = 1'b1; hit = ((c / 2) % 16) < 4; exp_balls--;
        tick(); i_throw = 1'b0;
        break;
      end
      if (c == 0 && spur) i_start = 1'b1;
      tick(); i_start = 1'b0;
    end
    chk("res_state", o_state, 4);
    chk_refresh("res", int'(hit));
    chk("res_balls", o_balls, exp_balls);
    if (hit) exp_slots[exp_idx + 1] = 1'b1;
    exp_idx = map6(m_prev);
    tick();
    chk("check_state", o_state, 5);
    chk("check_mem", mem_q, exp_slots);
    if (fw) force_win = 1'b1;
    if (spur) i_throw = 1'b1;
    win = fw || (exp_slots[6:1] == 6'h3f);
    tick(); force_win = 1'b0; i_throw = 1'b0;
    if (win || exp_balls == 0) begin
      chk("over_state", o_state, 6);
      chk("over_flag", o_over, 1);
      chk("over_win", o_win, int'(win));
      chk("over_balls", o_balls, exp_balls);
      over = 1'b1;
    end else begin
      chk("next_state", o_state, 3);
      chk("next_balls", o_balls, exp_balls);
      over = 1'b0;
    end
  endtask

  initial begin
    int rounds, thr, mode;
    tick(); tick();
    chk_reset_vals("por");
    i_rst_n = 1'b1;
    tick(); tick();
    chk("idle_hold", o_state, 0);

    // Directed game: hit at pos 2, miss at pos 9, timeout, throw on timeout cycle, forced win.
    start_game();
    play_round(4, 1'b0, 1'b0, ov);
    play_round(18, 1'b0, 1'b0, ov);
    play_round(-1, 1'b1, 1'b0, ov);
    play_round(63, 1'b0, 1'b0, ov);
    play_round(0, 1'b0, 1'b1, ov);
    chk("forced_over", ov, 1);
    i_throw = 1'b1; tick(); i_throw = 1'b0;
    chk("over_throw_state", o_state, 6);
    chk("over_throw_balls", o_balls, exp_balls);

    // Every throw misses: ten balls then loss.
    start_game();
    for (int r = 0; r < 10; r++) play_round(10 + r, r[0], 1'b0, ov);
    chk("miss_over", ov, 1);
    chk("miss_balls", o_balls, 0);
    chk("miss_win", o_win, 0);

    // Random games until enough refresh strobes have been seen.
    while (n_refresh < 1000) begin
      start_game();
      ov = 1'b0; rounds = 0;
      while (!ov) begin
        mode = $urandom_range(0, 7);
        if (mode < 4)       thr = $urandom_range(0, 7) + ($urandom_range(0, 1) * 32);
        else if (mode < 6)  thr = $urandom_range(8, 31);
        else if (mode == 6) thr = 63;
        else                thr = (rounds < 40) ? -1 : 0;
        play_round(thr, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), ov);
        rounds++;
      end
    end

    // Asynchronous reset in the middle of AIM.
    start_game();
    repeat (5) tick();
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    i_rst_n = 1'b1;
    tick();
    start_game();
    play_round(2, 1'b0, 1'b0, ov);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
